// File: rtl/clk_div_pkg.sv
// Purpose : shared definitions for the clock-enable / divided-clock generator.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: DIV_W_DEF (default divisor width), div_t (divisor word at default width).
package clk_div_pkg;

   localparam int DIV_W_DEF = 16;

   typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_gen_if.sv
// Purpose : control/status bundle between a divider client and clk_div_gen.
// Latency : n/a (wires only).
// Backpressure: none; every status output is free-running and sampled each cycle.
// Signals : en/load/div_val/sync driven by the master; clk_out/tick/pend driven by the slave.
interface clk_div_gen_if import clk_div_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = DIV_W_DEF
);

   logic [CHANNELS-1:0]       en;
   logic [CHANNELS-1:0]       load;
   logic [CHANNELS*DIV_W-1:0] div_val;
   logic                      sync;
   logic [CHANNELS-1:0]       clk_out;
   logic [CHANNELS-1:0]       tick;
   logic [CHANNELS-1:0]       pend;

   modport master (
      output en, load, div_val, sync,
      input  clk_out, tick, pend
   );

   modport slave (
      input  en, load, div_val, sync,
      output clk_out, tick, pend
   );

endinterface

// File: rtl/clk_div_chan.sv
// Purpose : one divider channel: phase counter, active/pending divisor, registered outputs.
// Latency : outputs registered; en/sync sampled high gives tick one cycle later.
// Backpressure: none; a load while running is parked in div_pnd until the period boundary.
// Ports   : clk, rst (sync, active-high), en, load, div_val, sync in; clk_out, tick, pend out.
module clk_div_chan import clk_div_pkg::*; #(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] div_val,
   input  logic             sync,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic [DIV_W-1:0] div_pnd_q, div_pnd_d;
   logic             pend_q, pend_d;
   logic             run_q, run_d;
   logic             wrap;
   logic             apply;

   // run_q is 1 only when div_act_q != 0, so the N-1 compare never underflows
   // while it matters.
   assign wrap = (phase_q == div_act_q - ONE);

   // Every case that restarts the period also commits the divisor:
   //  - en low      : channel stops, pending value applied immediately
   //  - sync        : forced restart at phase 0
   //  - not running : channel was stopped last cycle (first cycle after en rises)
   //  - wrap        : natural period boundary
   // A load coinciding with any of these is the newest value and wins over
   // div_pnd, so it is applied directly rather than parked.
   assign apply = !en || sync || !run_q || wrap;

   always_comb begin
      phase_d   = phase_q;
      div_act_d = div_act_q;
      div_pnd_d = div_pnd_q;
      pend_d    = pend_q;

      if (apply) begin
         if (load) begin
            div_act_d = div_val;
         end else if (pend_q) begin
            div_act_d = div_pnd_q;
         end
         pend_d  = 1'b0;
         phase_d = '0;
      end else begin
         phase_d = phase_q + ONE;
         if (load) begin
            div_pnd_d = div_val;
            pend_d    = 1'b1;
         end
      end

      run_d = en && (div_act_d != '0);
      if (!run_d) begin
         phase_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= '0;
         div_act_q <= '0;
         div_pnd_q <= '0;
         pend_q    <= 1'b0;
         run_q     <= 1'b0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         div_act_q <= div_act_d;
         div_pnd_q <= div_pnd_d;
         pend_q    <= pend_d;
         run_q     <= run_d;
         // Outputs are derived from next-state so they line up with phase_q.
         clk_out   <= run_d && (phase_d < (div_act_d >> 1));
         tick      <= run_d && (phase_d == '0);
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Purpose : multi-channel programmable clock-enable / divided-clock generator.
// Latency : all outputs registered; en or sync sampled high gives tick one cycle later.
// Backpressure: none; divisor changes wait for the channel's period boundary (pend shows it).
// Ports   : clk, rst (sync, active-high); bus (clk_div_gen_if.slave) carries en/load/div_val/sync
//           in and clk_out/tick/pend out, one bit (or DIV_W-bit slice) per channel.
module clk_div_gen import clk_div_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = DIV_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   clk_div_gen_if.slave bus
);

   logic [CHANNELS-1:0] clk_out_w;
   logic [CHANNELS-1:0] tick_w;
   logic [CHANNELS-1:0] pend_w;

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i++) begin : g_chan
         clk_div_chan #(
            .DIV_W (DIV_W)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en[i]),
            .load    (bus.load[i]),
            .div_val (bus.div_val[i*DIV_W +: DIV_W]),
            .sync    (bus.sync),
            .clk_out (clk_out_w[i]),
            .tick    (tick_w[i]),
            .pend    (pend_w[i])
         );
      end
   endgenerate

   assign bus.clk_out = clk_out_w;
   assign bus.tick    = tick_w;
   assign bus.pend    = pend_w;

endmodule

// File: tb/tb_clk_div_gen.sv
// Purpose : directed scoreboard bench for clk_div_gen (4 channels, 16-bit divisors).
// Latency : expectations are due on the falling edge after the rising edge that consumes the stimulus.
// Backpressure: n/a.
module tb_clk_div_gen;
   import clk_div_pkg::*;

   localparam int CH = 4;
   localparam int DW = 16;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      string      nm;
      int         due;
      int         ch;
      logic [2:0] exp;   // {clk_out, tick, pend}
   } exp_t;

   exp_t sbq[$];

   clk_div_gen_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

   clk_div_gen #(.CHANNELS(CH), .DIV_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Expectation for one channel, due after the next rising edge.
   task automatic exp_ch(input string nm, input int ch, input bit c, input bit t, input bit p);
      exp_t e;
      e.nm  = nm;
      e.due = cyc + 1;
      e.ch  = ch;
      e.exp = {c, t, p};
      sbq.push_back(e);
   endtask

   task automatic adv();
      @(negedge clk);
      bus.load = '0;
      bus.sync = 1'b0;
   endtask

   task automatic set_div(input int ch, input div_t v);
      bus.div_val[ch*DW +: DW] = v;
   endtask

   // Monitor: pops every expectation that has come due and compares it.
   initial begin
      exp_t       e;
      logic [2:0] act;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e   = sbq.pop_front();
            act = {bus.clk_out[e.ch], bus.tick[e.ch], bus.pend[e.ch]};
            total++;
            if (e.due != cyc || act !== e.exp) begin
               bad++;
               $display("FAIL %s ch%0d cyc=%0d clk_out/tick/pend got=%b required=%b",
                        e.nm, e.ch, cyc, act, e.exp);
            end
         end
      end
   end

   initial begin
      bit [2:0] b_tab [8];
      b_tab = '{3'b110, 3'b100, 3'b001, 3'b001, 3'b001, 3'b110, 3'b000, 3'b110};

      rst         = 1'b1;
      bus.en      = '0;
      bus.load    = '0;
      bus.div_val = '0;
      bus.sync    = 1'b0;

      // Reset wins over en/load presented at the same time.
      @(negedge clk);
      bus.en   = '1;
      bus.load = '1;
      for (int c = 0; c < CH; c++) set_div(c, 16'd5);
      for (int c = 0; c < CH; c++) exp_ch("reset", c, 0, 0, 0);
      adv();
      total++;
      if ({bus.clk_out, bus.tick, bus.pend} !== '0) begin
         bad++;
         $display("FAIL reset_direct clk_out=%b tick=%b pend=%b required all 0",
                  bus.clk_out, bus.tick, bus.pend);
      end
      bus.en = '0;
      for (int c = 0; c < CH; c++) exp_ch("reset_hold", c, 0, 0, 0);
      adv();
      total++;
      if ({bus.clk_out, bus.tick, bus.pend} !== '0) begin
         bad++;
         $display("FAIL reset_hold_direct clk_out=%b tick=%b pend=%b required all 0",
                  bus.clk_out, bus.tick, bus.pend);
      end

      // A: ch0 N=4, tick every 4, clk_out 1100.
      rst = 1'b0;
      set_div(0, 16'd4);
      bus.load[0] = 1'b1;
      exp_ch("a_load_stopped", 0, 0, 0, 0);
      adv();
      bus.en[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_ch("a_n4", 0, (k % 4) < 2, (k % 4) == 0, 0);
         adv();
      end
      bus.en[0] = 1'b0;
      exp_ch("a_stop", 0, 0, 0, 0);
      adv();

      // B: ch1 N=5, load 2 at phase 1; pend for 3 cycles then toggle.
      set_div(1, 16'd5);
      bus.load[1] = 1'b1;
      exp_ch("b_load", 1, 0, 0, 0);
      adv();
      bus.en[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            set_div(1, 16'd2);
            bus.load[1] = 1'b1;
         end
         exp_ch("b_5to2", 1, b_tab[k][2], b_tab[k][1], b_tab[k][0]);
         adv();
      end
      bus.en[1] = 1'b0;
      exp_ch("b_stop", 1, 0, 0, 0);
      adv();

      // C: ch0 N=3 and ch1 N=7 out of phase, then sync.
      set_div(0, 16'd3);
      set_div(1, 16'd7);
      bus.load[1:0] = 2'b11;
      exp_ch("c_load", 0, 0, 0, 0);
      exp_ch("c_load", 1, 0, 0, 0);
      adv();
      bus.en[0] = 1'b1;
      exp_ch("c_start0", 0, 1, 1, 0);
      adv();
      bus.en[1] = 1'b1;
      exp_ch("c_run0", 0, 0, 0, 0);
      exp_ch("c_start1", 1, 1, 1, 0);
      adv();
      exp_ch("c_run0", 0, 0, 0, 0);
      exp_ch("c_run1", 1, 1, 0, 0);
      adv();
      exp_ch("c_run0", 0, 1, 1, 0);
      exp_ch("c_run1", 1, 1, 0, 0);
      adv();
      bus.sync = 1'b1;
      exp_ch("c_sync", 0, 1, 1, 0);
      exp_ch("c_sync", 1, 1, 1, 0);
      adv();
      for (int k = 1; k <= 7; k++) begin
         exp_ch("c_after0", 0, (k % 3) < 1, (k % 3) == 0, 0);
         exp_ch("c_after1", 1, (k % 7) < 3, (k % 7) == 0, 0);
         adv();
      end
      bus.en[1:0] = 2'b00;
      exp_ch("c_stop", 0, 0, 0, 0);
      exp_ch("c_stop", 1, 0, 0, 0);
      adv();

      // D: ch2 N=1 (tick constant, clk_out 0); ch3 load 0 while running.
      set_div(2, 16'd1);
      set_div(3, 16'd4);
      bus.load[3:2] = 2'b11;
      exp_ch("d_load", 2, 0, 0, 0);
      exp_ch("d_load", 3, 0, 0, 0);
      adv();
      bus.en[3:2] = 2'b11;
      exp_ch("d_n1", 2, 0, 1, 0);
      exp_ch("d_n4", 3, 1, 1, 0);
      adv();
      exp_ch("d_n1", 2, 0, 1, 0);
      exp_ch("d_n4", 3, 1, 0, 0);
      adv();
      set_div(3, 16'd0);
      bus.load[3] = 1'b1;
      exp_ch("d_n1", 2, 0, 1, 0);
      exp_ch("d_zero_pend", 3, 0, 0, 1);
      adv();
      exp_ch("d_n1", 2, 0, 1, 0);
      exp_ch("d_zero_pend", 3, 0, 0, 1);
      adv();
      for (int k = 0; k < 3; k++) begin
         exp_ch("d_n1", 2, 0, 1, 0);
         exp_ch("d_zero_stopped", 3, 0, 0, 0);
         adv();
      end
      bus.en[3:2] = 2'b00;
      exp_ch("d_stop", 2, 0, 0, 0);
      adv();

      // E: ch0 N=6, reload pending, reset mid-period.
      set_div(0, 16'd6);
      bus.load[0] = 1'b1;
      exp_ch("e_load", 0, 0, 0, 0);
      adv();
      bus.en[0] = 1'b1;
      exp_ch("e_n6", 0, 1, 1, 0);
      adv();
      exp_ch("e_n6", 0, 1, 0, 0);
      adv();
      set_div(0, 16'd2);
      bus.load[0] = 1'b1;
      exp_ch("e_pend", 0, 1, 0, 1);
      adv();
      rst = 1'b1;
      exp_ch("e_rst", 0, 0, 0, 0);
      adv();
      total++;
      if (bus.pend[0] !== 1'b0 || bus.tick[0] !== 1'b0 || bus.clk_out[0] !== 1'b0) begin
         bad++;
         $display("FAIL e_rst_direct clk_out/tick/pend got=%b%b%b required=000",
                  bus.clk_out[0], bus.tick[0], bus.pend[0]);
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_ch("e_no_tick", 0, 0, 0, 0);
         adv();
      end
      set_div(0, 16'd6);
      bus.load[0] = 1'b1;
      exp_ch("e_reload", 0, 1, 1, 0);
      adv();
      exp_ch("e_reload", 0, 1, 0, 0);
      adv();
      bus.en[0] = 1'b0;
      exp_ch("e_stop", 0, 0, 0, 0);
      adv();

      // F: en falling applies the pending divisor immediately.
      set_div(1, 16'd4);
      bus.load[1] = 1'b1;
      exp_ch("f_load", 1, 0, 0, 0);
      adv();
      bus.en[1] = 1'b1;
      exp_ch("f_n4", 1, 1, 1, 0);
      adv();
      set_div(1, 16'd2);
      bus.load[1] = 1'b1;
      exp_ch("f_pend", 1, 1, 0, 1);
      adv();
      bus.en[1] = 1'b0;
      exp_ch("f_en_low", 1, 0, 0, 0);
      adv();
      bus.en[1] = 1'b1;
      exp_ch("f_n2", 1, 1, 1, 0);
      adv();
      exp_ch("f_n2", 1, 0, 0, 0);
      adv();
      exp_ch("f_n2", 1, 1, 1, 0);
      adv();
      bus.en = '0;

      for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         total++;
         bad++;
         $display("FAIL %s ch%0d got=never-checked required=%b", e.nm, e.ch, e.exp);
      end

      if (bad == 0) $display("PASS");
      else          $display("FAIL");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
